// File: rtl/enc_pkg.sv
// Shared types and helpers for the streaming 4x2 request encoder.
package enc_pkg;

    localparam int unsigned N_DEFAULT = 4;
    localparam int unsigned W_DEFAULT = $clog2(N_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Highest set index of v; result is meaningless when v == 0.
    function automatic logic [W_DEFAULT-1:0] prio_idx(input logic [N_DEFAULT-1:0] v);
        logic [W_DEFAULT-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N_DEFAULT; i++) begin
            if (v[i]) idx = W_DEFAULT'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_encoder_4x2.sv
// Combinational priority encoder: highest set bit wins, any_set flags a non-empty vector.
module priority_encoder_4x2 #(
    parameter int unsigned N = enc_pkg::N_DEFAULT,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any_set
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any_set = |vec;

endmodule

// File: rtl/encoder_4x2_stream.sv
// Latches request pulses into a pending set and streams them out as binary codes,
// highest index first, over a valid/ready handshake.
module encoder_4x2_stream
    import enc_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         overflow
);

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic [N-1:0]   pending_q, pending_d;
    logic           valid_q, valid_d;
    logic           overflow_q, overflow_d;

    logic [W-1:0]   top_idx;
    logic           top_any;
    logic           load;
    logic [N-1:0]   clr;

    priority_encoder_4x2 #(.N(N)) u_prio (
        .vec     (pending_q),
        .idx     (top_idx),
        .any_set (top_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state: load a new code from IDLE, or on a completed handshake in HOLD.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        load       = 1'b0;
        clr        = '0;

        case (state_q)
            IDLE: begin
                if (top_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (top_any) load    = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            code_d = top_idx;
            clr    = N'(1) << top_idx;
        end

        // Set wins over clear so a same-edge re-request is not lost.
        pending_d  = (pending_q & ~clr) | req;
        overflow_d = |(req & pending_q & ~clr);
        valid_d    = (state_d == HOLD);
    end

    assign code      = code_q;
    assign out_valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_encoder_4x2_stream.sv
// Directed self-checking bench for encoder_4x2_stream.
module tb_encoder_4x2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pending;
    logic       overflow;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    encoder_4x2_stream dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .code      (code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] c,
                           input logic [3:0] p, input logic o);
        chk({tag, ".valid"},    32'(out_valid), 32'(v));
        chk({tag, ".code"},     32'(code),      32'(c));
        chk({tag, ".pending"},  32'(pending),   32'(p));
        chk({tag, ".overflow"}, 32'(overflow),  32'(o));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_out("post_reset_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Single request
        out_ready = 1'b1; req = 4'b0100;
        @(negedge clk); req = 4'b0000;
        chk_out("single.k", 1'b0, 2'd0, 4'b0100, 1'b0);
        @(negedge clk);
        chk_out("single.k1", 1'b1, 2'd2, 4'b0000, 1'b0);
        @(negedge clk);
        chk_out("single.k2", 1'b0, 2'd2, 4'b0000, 1'b0);

        // Multi-hot burst drains highest first with no bubbles
        req = 4'b1011;
        @(negedge clk); req = 4'b0000;
        chk_out("multi.cap", 1'b0, 2'd2, 4'b1011, 1'b0);
        @(negedge clk);
        chk_out("multi.c3", 1'b1, 2'd3, 4'b0011, 1'b0);
        @(negedge clk);
        chk_out("multi.c1", 1'b1, 2'd1, 4'b0001, 1'b0);
        @(negedge clk);
        chk_out("multi.c0", 1'b1, 2'd0, 4'b0000, 1'b0);
        @(negedge clk);
        chk_out("multi.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Backpressure holds code stable
        out_ready = 1'b0; req = 4'b0011;
        @(negedge clk); req = 4'b0000;
        chk_out("bp.cap", 1'b0, 2'd0, 4'b0011, 1'b0);
        @(negedge clk);
        chk_out("bp.load", 1'b1, 2'd1, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_out("bp.stall", 1'b1, 2'd1, 4'b0001, 1'b0);
        end

        // Collision on an already-pending bit while stalled
        req = 4'b0001;
        @(negedge clk); req = 4'b0000;
        chk_out("ovf.pulse", 1'b1, 2'd1, 4'b0001, 1'b1);
        @(negedge clk);
        chk_out("ovf.clear", 1'b1, 2'd1, 4'b0001, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("bp.c0", 1'b1, 2'd0, 4'b0000, 1'b0);
        @(negedge clk);
        chk_out("bp.idle", 1'b0, 2'd0, 4'b0000, 1'b0);

        // Request on the bit being loaded this edge stays pending, no overflow
        req = 4'b0100;
        @(negedge clk);
        chk_out("setwin.cap", 1'b0, 2'd0, 4'b0100, 1'b0);
        @(negedge clk); req = 4'b0000;
        chk_out("setwin.load", 1'b1, 2'd2, 4'b0100, 1'b0);
        @(negedge clk);
        chk_out("setwin.again", 1'b1, 2'd2, 4'b0000, 1'b0);
        @(negedge clk);
        chk_out("setwin.idle", 1'b0, 2'd2, 4'b0000, 1'b0);

        // Re-request of the held code is re-emitted later
        out_ready = 1'b0; req = 4'b1000;
        @(negedge clk); req = 4'b0000;
        chk_out("rereq.cap", 1'b0, 2'd2, 4'b1000, 1'b0);
        @(negedge clk);
        chk_out("rereq.load", 1'b1, 2'd3, 4'b0000, 1'b0);
        req = 4'b1000;
        @(negedge clk); req = 4'b0000;
        chk_out("rereq.held", 1'b1, 2'd3, 4'b1000, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk_out("rereq.emit", 1'b1, 2'd3, 4'b0000, 1'b0);
        @(negedge clk);
        chk_out("rereq.idle", 1'b0, 2'd3, 4'b0000, 1'b0);

        // Asynchronous reset mid-HOLD discards everything
        out_ready = 1'b0; req = 4'b1110;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        chk_out("rst.pre", 1'b1, 2'd3, 4'b0110, 1'b0);
        #2 rst = 1'b1;
        #1 chk_out("rst.async", 1'b0, 2'd0, 4'b0000, 1'b0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_out("rst.quiet", 1'b0, 2'd0, 4'b0000, 1'b0);
        req = 4'b0010;
        @(negedge clk); req = 4'b0000;
        @(negedge clk);
        chk_out("rst.fresh", 1'b1, 2'd1, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
